mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer sitting between the CPU's instruction-fetch port and load/store data port on one side and the single shared simulation RAM on the other. Accepts one request at a time, drives the RAM strobe/address/width/data signals for exactly one cycle, waits for read data, and returns a one-cycle acknowledge to the granted requester. It generates write acknowledges itself, since the RAM does not acknowledge writes, and bounds every read with a timeout.

## Interface
- TIMEOUT, 4: max cycles in WAIT before a read is aborted with error; legal range 2..255.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_req  in  1  fetch request, level; held until i_ack
- i_addr  in  32  fetch byte address, always word-width read
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  32  fetch read data, valid with i_ack
- d_req  in  1  data request, level; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_width  in  2  0 = byte, 1 = half, 2 = word; passed through unchanged
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  32  data read data, valid with d_ack
- d_err  out  1  read timeout flag, valid only with d_ack
- mem_addr, mem_write_data  out  32  to RAM
- mem_width  out  2  to RAM
- mem_read_valid, mem_write_valid  out  1  RAM strobes, never both high
- mem_read_data  in  32  from RAM
- mem_valid  in  1  RAM read-complete, one cycle after sampled mem_read_valid
- arb_busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered.
- IDLE: if i_req or d_req, select grant, latch op/addr/width/wdata into mem_* outputs, raise the matching strobe, go to REQ. Fetch: mem_width = 2, mem_write_valid = 0.
- REQ: strobe is high this cycle only. Next: strobes to 0. Write goes to RESP; read goes to WAIT with the timeout counter cleared.
- WAIT: mem_valid = 1 captures mem_read_data into the shared rdata register and goes to RESP. Otherwise the counter increments; at count TIMEOUT-1 go to RESP with err set and rdata = 0.
- RESP: the granted port's ack is high for one cycle; d_err is high if a timeout occurred. Then go to IDLE, clearing err.
- i_rdata and d_rdata both show the shared rdata register. It holds until the next read completes. Writes leave it unchanged.
- Requester rule: a requester drops or replaces its req on the edge where it samples ack. The arbiter treats req seen in IDLE as a new request.
- mem_valid outside WAIT is ignored, including late responses after a timeout.
- Conflict (both reqs high in IDLE): resolved per Configuration. With no conflict, the sole requester is always granted.
- Reset (any state, any cycle): state = IDLE, all outputs 0 (mem_* buses, strobes, acks, d_err, rdata, arb_busy), last-grant = fetch. Any in-flight RAM access is abandoned without ack.

## Timing
- Read, no contention: req seen in IDLE at cycle 0, strobe in cycle 1, mem_valid in cycle 2, ack in cycle 3. Latency is 3 cycles, so back-to-back throughput is one read per 4 cycles.
- Write: req in cycle 0, strobe in cycle 1, ack in cycle 2. Latency is 2 cycles, one write per 3 cycles.
- Timeout read: ack + d_err exactly TIMEOUT + 2 cycles after the IDLE cycle.
- A losing requester waits for the full winner transaction plus one IDLE cycle.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on conflict, grant the port not granted last. Last-grant updates on every grant.
- Undefined: fixed priority, data port always wins conflicts. Last-grant logic is not built.

## Test plan
- Fetch only, i_addr = 0x10, RAM word 0x0000_0013 -> i_ack in cycle 3, i_rdata = 0x13, one mem_read_valid pulse with mem_width = 2.
- Data byte write d_addr = 0x21, d_wdata = 0xAB, d_width = 0 -> one mem_write_valid pulse, d_ack 2 cycles later, d_err = 0; readback of 0x21 returns 0xAB.
- Both req held high for 4 transactions -> with MEM_ARB_ROUND_ROBIN_EN, grants alternate D, I, D, I; without it, grants are D, D, D, D while d_req stays high.
- RAM model suppresses mem_valid, TIMEOUT = 4 -> d_ack with d_err = 1 and d_rdata = 0 six cycles after request; a later stray mem_valid in IDLE is ignored.
- rst pulled low during WAIT -> outputs 0 immediately, no ack, arb_busy = 0; the next request completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared RAM bus.
// The master modport is the arbiter's view. The slave modport is the view
// of the surrounding CPU ports and RAM.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_width;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [1:0]  mem_width;
    logic        mem_read_valid;
    logic        mem_write_valid;
    logic [31:0] mem_read_data;
    logic        mem_valid;

    logic        arb_busy;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_width,
               mem_read_data, mem_valid,
        output i_ack, i_rdata, d_ack, d_rdata, d_err,
               mem_addr, mem_write_data, mem_width, mem_read_valid,
               mem_write_valid, arb_busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_width,
               mem_read_data, mem_valid,
        input  i_ack, i_rdata, d_ack, d_rdata, d_err,
               mem_addr, mem_write_data, mem_width, mem_read_valid,
               mem_write_valid, arb_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter between the instruction-fetch and load/store ports and a
// single shared RAM. One access at a time: strobe the RAM for one cycle, wait
// for read data (bounded by TIMEOUT), then pulse the granted port's ack.
// Writes are acknowledged locally because the RAM never answers them.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on
// conflicts. Otherwise the data port always wins conflicts.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        grant_data, grant_data_nxt;
    logic        is_write, is_write_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [1:0]  width_q, width_nxt;
    logic        rd_vld_q, rd_vld_nxt;
    logic        wr_vld_q, wr_vld_nxt;
    logic [31:0] rdata_q, rdata_nxt;
    logic        err_q, err_nxt;
    logic        i_ack_q, i_ack_nxt;
    logic        d_ack_q, d_ack_nxt;
    logic [7:0]  cnt_q, cnt_nxt;
    logic        busy_q, busy_nxt;
    logic        pick_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_data, last_data_nxt;
    assign pick_data = bus.d_req && (!bus.i_req || !last_data);
`else
    assign pick_data = bus.d_req;
`endif

    assign bus.i_ack           = i_ack_q;
    assign bus.d_ack           = d_ack_q;
    assign bus.i_rdata         = rdata_q;
    assign bus.d_rdata         = rdata_q;
    assign bus.d_err           = err_q;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_write_data  = wdata_q;
    assign bus.mem_width       = width_q;
    assign bus.mem_read_valid  = rd_vld_q;
    assign bus.mem_write_valid = wr_vld_q;
    assign bus.arb_busy        = busy_q;

    // Next-state and next-output logic; strobes and acks default low so they pulse.
    always_comb begin
        state_nxt      = state;
        grant_data_nxt = grant_data;
        is_write_nxt   = is_write;
        addr_nxt       = addr_q;
        wdata_nxt      = wdata_q;
        width_nxt      = width_q;
        rd_vld_nxt     = 1'b0;
        wr_vld_nxt     = 1'b0;
        rdata_nxt      = rdata_q;
        err_nxt        = err_q;
        i_ack_nxt      = 1'b0;
        d_ack_nxt      = 1'b0;
        cnt_nxt        = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_data_nxt  = last_data;
`endif
        case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_nxt      = REQ;
                    grant_data_nxt = pick_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_data_nxt  = pick_data;
`endif
                    if (pick_data) begin
                        is_write_nxt = bus.d_we;
                        addr_nxt     = bus.d_addr;
                        wdata_nxt    = bus.d_wdata;
                        width_nxt    = bus.d_width;
                        rd_vld_nxt   = !bus.d_we;
                        wr_vld_nxt   = bus.d_we;
                    end else begin
                        is_write_nxt = 1'b0;
                        addr_nxt     = bus.i_addr;
                        wdata_nxt    = 32'h0;
                        width_nxt    = 2'd2;
                        rd_vld_nxt   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (is_write) begin
                    state_nxt = RESP;
                    d_ack_nxt = grant_data;
                    i_ack_nxt = !grant_data;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = 8'h0;
                end
            end
            WAIT: begin
                if (bus.mem_valid) begin
                    state_nxt = RESP;
                    rdata_nxt = bus.mem_read_data;
                    d_ack_nxt = grant_data;
                    i_ack_nxt = !grant_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = RESP;
                    rdata_nxt = 32'h0;
                    err_nxt   = 1'b1;
                    d_ack_nxt = grant_data;
                    i_ack_nxt = !grant_data;
                end else begin
                    cnt_nxt = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                err_nxt   = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered-output update; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_data <= 1'b0;
            is_write   <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            width_q    <= 2'd0;
            rd_vld_q   <= 1'b0;
            wr_vld_q   <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            cnt_q      <= 8'h0;
            busy_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data  <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            grant_data <= grant_data_nxt;
            is_write   <= is_write_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            width_q    <= width_nxt;
            rd_vld_q   <= rd_vld_nxt;
            wr_vld_q   <= wr_vld_nxt;
            rdata_q    <= rdata_nxt;
            err_q      <= err_nxt;
            i_ack_q    <= i_ack_nxt;
            d_ack_q    <= d_ack_nxt;
            cnt_q      <= cnt_nxt;
            busy_q     <= busy_nxt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data  <= last_data_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT = 4 and a small byte-addressed
// RAM model that answers reads one cycle after the strobe.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    logic        suppress;
    logic        stray_valid;
    logic        ram_valid;
    logic [31:0] ram_rdata;
    logic        ram_loaded = 1'b0;
    logic [7:0]  ram [0:255];

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_valid     = ram_valid | stray_valid;
    assign bus.mem_read_data = ram_rdata;

    always #5 clk = ~clk;

    // RAM model: preload on first edge, byte-lane writes, reads answered a cycle later.
    always @(posedge clk) begin
        ram_valid <= 1'b0;
        if (!ram_loaded) begin
            for (int k = 0; k < 256; k++) ram[k] <= 8'h00;
            ram[8'h10] <= 8'h13;
            ram_loaded <= 1'b1;
        end else begin
            if (bus.mem_write_valid) begin
                ram[bus.mem_addr[7:0]] <= bus.mem_write_data[7:0];
                if (bus.mem_width != 2'd0)
                    ram[bus.mem_addr[7:0] + 8'd1] <= bus.mem_write_data[15:8];
                if (bus.mem_width == 2'd2) begin
                    ram[bus.mem_addr[7:0] + 8'd2] <= bus.mem_write_data[23:16];
                    ram[bus.mem_addr[7:0] + 8'd3] <= bus.mem_write_data[31:24];
                end
            end
            if (bus.mem_read_valid && !suppress) begin
                ram_valid <= 1'b1;
                case (bus.mem_width)
                    2'd0:    ram_rdata <= {24'h0, ram[bus.mem_addr[7:0]]};
                    2'd1:    ram_rdata <= {16'h0, ram[bus.mem_addr[7:0] + 8'd1],
                                           ram[bus.mem_addr[7:0]]};
                    default: ram_rdata <= {ram[bus.mem_addr[7:0] + 8'd3],
                                           ram[bus.mem_addr[7:0] + 8'd2],
                                           ram[bus.mem_addr[7:0] + 8'd1],
                                           ram[bus.mem_addr[7:0]]};
                endcase
            end
        end
    end

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwe,
                                 input logic [31:0] daddr, input logic [31:0] dwdata,
                                 input logic [1:0] dwidth);
        bus.i_req   = ireq;
        bus.i_addr  = iaddr;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwdata;
        bus.d_width = dwidth;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        suppress    = 1'b0;
        stray_valid = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        step();
        step();
        checkOutput("rst_busy", 32'(bus.arb_busy), 32'h0);
        checkOutput("rst_rdvld", 32'(bus.mem_read_valid), 32'h0);
        checkOutput("rst_iack", 32'(bus.i_ack), 32'h0);
        checkOutput("rst_rdata", bus.d_rdata, 32'h0);
        checkOutput("rst_addr", bus.mem_addr, 32'h0);
        rst = 1'b1;
        step();

        // Fetch word read at 0x10
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        step();
        checkOutput("f_c1_rdvld", 32'(bus.mem_read_valid), 32'h1);
        checkOutput("f_c1_wrvld", 32'(bus.mem_write_valid), 32'h0);
        checkOutput("f_c1_width", 32'(bus.mem_width), 32'h2);
        checkOutput("f_c1_addr", bus.mem_addr, 32'h10);
        checkOutput("f_c1_busy", 32'(bus.arb_busy), 32'h1);
        step();
        checkOutput("f_c2_rdvld", 32'(bus.mem_read_valid), 32'h0);
        checkOutput("f_c2_iack", 32'(bus.i_ack), 32'h0);
        step();
        checkOutput("f_c3_iack", 32'(bus.i_ack), 32'h1);
        checkOutput("f_c3_rdata", bus.i_rdata, 32'h13);
        checkOutput("f_c3_dack", 32'(bus.d_ack), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        step();
        checkOutput("f_c4_iack", 32'(bus.i_ack), 32'h0);
        checkOutput("f_c4_busy", 32'(bus.arb_busy), 32'h0);

        // Byte write 0xAB to 0x21
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h21, 32'hAB, 2'd0);
        step();
        checkOutput("w_c1_wrvld", 32'(bus.mem_write_valid), 32'h1);
        checkOutput("w_c1_rdvld", 32'(bus.mem_read_valid), 32'h0);
        checkOutput("w_c1_width", 32'(bus.mem_width), 32'h0);
        checkOutput("w_c1_addr", bus.mem_addr, 32'h21);
        checkOutput("w_c1_wdata", bus.mem_write_data, 32'hAB);
        step();
        checkOutput("w_c2_dack", 32'(bus.d_ack), 32'h1);
        checkOutput("w_c2_derr", 32'(bus.d_err), 32'h0);
        checkOutput("w_c2_wrvld", 32'(bus.mem_write_valid), 32'h0);
        checkOutput("w_c2_rdata_kept", bus.d_rdata, 32'h13);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        step();
        checkOutput("w_c3_dack", 32'(bus.d_ack), 32'h0);

        // Byte readback of 0x21
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h21, 32'h0, 2'd0);
        step();
        checkOutput("rb_c1_rdvld", 32'(bus.mem_read_valid), 32'h1);
        step();
        step();
        checkOutput("rb_c3_dack", 32'(bus.d_ack), 32'h1);
        checkOutput("rb_c3_drdata", bus.d_rdata, 32'hAB);
        checkOutput("rb_c3_irdata", bus.i_rdata, 32'hAB);
        checkOutput("rb_c3_derr", 32'(bus.d_err), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        step();

        // Reset asserted while a fetch sits in WAIT
        suppress = 1'b1;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        step();
        step();
        step();
        checkOutput("rw_pre_busy", 32'(bus.arb_busy), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("rw_busy", 32'(bus.arb_busy), 32'h0);
        checkOutput("rw_rdata", bus.i_rdata, 32'h0);
        checkOutput("rw_addr", bus.mem_addr, 32'h0);
        checkOutput("rw_iack", 32'(bus.i_ack), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        suppress = 1'b0;
        step();
        checkOutput("rw_noack", 32'(bus.i_ack), 32'h0);
        rst = 1'b1;
        step();
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        step();
        step();
        step();
        checkOutput("rw_next_iack", 32'(bus.i_ack), 32'h1);
        checkOutput("rw_next_rdata", bus.i_rdata, 32'h13);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        step();

        // Both ports requesting for four transactions
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h21, 32'h0, 2'd0);
        for (int t = 0; t < 4; t++) begin
            logic exp_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (t % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            step();
            checkOutput($sformatf("cf%0d_addr", t), bus.mem_addr, exp_d ? 32'h21 : 32'h10);
            step();
            step();
            checkOutput($sformatf("cf%0d_dack", t), 32'(bus.d_ack), 32'(exp_d));
            checkOutput($sformatf("cf%0d_iack", t), 32'(bus.i_ack), 32'(!exp_d));
            checkOutput($sformatf("cf%0d_rdata", t), bus.d_rdata, exp_d ? 32'hAB : 32'h13);
            step();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        step();

        // Data read with RAM silent: timeout
        suppress = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h21, 32'h0, 2'd0);
        for (int c = 1; c <= 5; c++) step();
        checkOutput("to_c5_dack", 32'(bus.d_ack), 32'h0);
        step();
        checkOutput("to_c6_dack", 32'(bus.d_ack), 32'h1);
        checkOutput("to_c6_derr", 32'(bus.d_err), 32'h1);
        checkOutput("to_c6_rdata", bus.d_rdata, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        suppress = 1'b0;
        step();
        checkOutput("to_c7_dack", 32'(bus.d_ack), 32'h0);
        checkOutput("to_c7_derr", 32'(bus.d_err), 32'h0);
        checkOutput("to_c7_busy", 32'(bus.arb_busy), 32'h0);

        // Stray mem_valid while idle
        stray_valid = 1'b1;
        step();
        stray_valid = 1'b0;
        checkOutput("stray_busy", 32'(bus.arb_busy), 32'h0);
        checkOutput("stray_rdata", bus.d_rdata, 32'h0);
        checkOutput("stray_dack", 32'(bus.d_ack), 32'h0);
        step();
        checkOutput("stray_dack2", 32'(bus.d_ack), 32'h0);
        checkOutput("stray_iack2", 32'(bus.i_ack), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
